// File: rtl/muon_pkg.sv
// muon_pkg: shared types and constants for the muon lifetime TDC.
//   tdc_state_t - measurement FSM states (IDLE / TIMING / HOLDOFF)
//   BCD_DIGITS  - number of BCD digits in every displayed count
//   BCD_MAX     - largest 4-digit BCD value (9999)
//   SHADOW_W    - width of the binary shadow of the running interval count
//   bcd_inc()   - ripple-carry increment of a 4-digit BCD word (9999 wraps to 0000)
package muon_pkg;

    localparam int          BCD_DIGITS = 4;
    localparam logic [15:0] BCD_MAX    = 16'h9999;
    localparam int          SHADOW_W   = 14;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TIMING  = 2'd1,
        HOLDOFF = 2'd2
    } tdc_state_t;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_counter4.sv
// bcd_counter4: 4-digit BCD up-counter.
// Ports:
//   clk   - system clock
//   rst   - synchronous reset, active-high (value -> 0)
//   clr   - synchronous clear (value -> 0), wins over en
//   en    - increment by one this cycle
//   value - current count, BCD [15:12] thousands .. [3:0] units
// With SATURATE set, the counter holds at 9999 instead of wrapping.
import muon_pkg::*;

module bcd_counter4 #(
    parameter bit SATURATE = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    output logic [15:0] value
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value <= '0;
        end else if (en) begin
            if (!(SATURATE && (value == BCD_MAX))) begin
                value <= bcd_inc(value);
            end
        end
    end

endmodule

// File: rtl/muon_tdc.sv
// muon_tdc: time-to-digital converter for the muon lifetime measurement.
// Measures the time from a start edge to the next stop edge and reports it
// as 4-digit BCD, together with a saturating BCD count of recorded decays.
// Ports:
//   clk          - 100 MHz system clock
//   rst          - synchronous reset, active-high
//   start_in     - asynchronous start pulse (rising edge significant)
//   stop_in      - asynchronous stop pulse (rising edge significant)
//   clear_counts - synchronous clear of digits_D and decay_count
//   digits_D     - last recorded interval, BCD
//   decay_count  - number of recorded decays, BCD, holds at 9999
//   meas_valid   - one-cycle pulse when digits_D is updated
//   timeout      - one-cycle pulse when the window expires without a stop
//   busy         - high while the FSM is in TIMING or HOLDOFF
//   state_dbg    - current FSM state, for observation only
// meas_valid and timeout are single-cycle event strobes with no back-pressure:
// a consumer must sample them on the cycle they are high, there is no ready.
import muon_pkg::*;

module muon_tdc #(
    parameter int TICK_DIV       = 1,
    parameter int WINDOW         = 2000,
    parameter int HOLDOFF_CYCLES = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_in,
    input  logic        stop_in,
    input  logic        clear_counts,
    output logic [15:0] digits_D,
    output logic [15:0] decay_count,
    output logic        meas_valid,
    output logic        timeout,
    output logic        busy,
    output tdc_state_t  state_dbg
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HO_W  = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

    // [0] and [1] form the synchronizer, [2] is the edge history. All three
    // reset to 1 so an input already high when reset releases gives no edge.
    logic [2:0] start_sh;
    logic [2:0] stop_sh;
    logic       start_e;
    logic       stop_e;

    always_ff @(posedge clk) begin
        if (rst) begin
            start_sh <= 3'b111;
            stop_sh  <= 3'b111;
        end else begin
            start_sh <= {start_sh[1:0], start_in};
            stop_sh  <= {stop_sh[1:0], stop_in};
        end
    end

    assign start_e = start_sh[1] & ~start_sh[2];
    assign stop_e  = stop_sh[1] & ~stop_sh[2];

    tdc_state_t          state;
    tdc_state_t          state_nx;
    logic [PRE_W-1:0]    pre;
    logic [SHADOW_W-1:0] run_bin;
    logic [15:0]         run_bcd;
    logic [15:0]         elapsed_bcd;
    logic [HO_W-1:0]     ho_cnt;
    logic                wrap;
    logic                win_end;
    logic                ho_last;
    logic                run_clr;
    logic                run_en;
    logic                rec;
    logic                win_hit;

    assign wrap    = (pre == PRE_W'(TICK_DIV - 1));
    // The elapsed value includes this cycle's increment, so the window is
    // reached when the shadow is one below WINDOW and the prescaler wraps.
    assign win_end = wrap && (run_bin == SHADOW_W'(WINDOW - 1));
    assign ho_last = (ho_cnt == HO_W'(HOLDOFF_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        run_clr  = 1'b0;
        run_en   = 1'b0;
        rec      = 1'b0;
        win_hit  = 1'b0;
        case (state)
            IDLE: begin
                if (start_e) begin
                    run_clr  = 1'b1;
                    state_nx = TIMING;
                end
            end
            TIMING: begin
                run_en = wrap;
                if (stop_e) begin
                    rec      = 1'b1;
                    state_nx = HOLDOFF;
                end else if (win_end) begin
                    win_hit  = 1'b1;
                    state_nx = IDLE;
                end
            end
            HOLDOFF: begin
                if (ho_last) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Prescaler and binary shadow of the running interval count.
    always_ff @(posedge clk) begin
        if (rst || run_clr) begin
            pre     <= '0;
            run_bin <= '0;
        end else if (state == TIMING) begin
            pre <= wrap ? '0 : pre + PRE_W'(1);
            if (wrap) begin
                run_bin <= run_bin + SHADOW_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (state != HOLDOFF)) begin
            ho_cnt <= '0;
        end else begin
            ho_cnt <= ho_cnt + HO_W'(1);
        end
    end

    // Never passes WINDOW <= 9999, so the non-saturating counter cannot wrap.
    bcd_counter4 #(.SATURATE(1'b0)) u_run_count (
        .clk   (clk),
        .rst   (rst),
        .clr   (run_clr),
        .en    (run_en),
        .value (run_bcd)
    );

    bcd_counter4 #(.SATURATE(1'b1)) u_decay_count (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear_counts),
        .en    (rec),
        .value (decay_count)
    );

    assign elapsed_bcd = wrap ? bcd_inc(run_bcd) : run_bcd;

    always_ff @(posedge clk) begin
        if (rst) begin
            digits_D   <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // A clear arriving with a stop record wins; the strobe still fires.
            if (clear_counts) begin
                digits_D <= '0;
            end else if (rec) begin
                digits_D <= elapsed_bcd;
            end
            meas_valid <= rec;
            timeout    <= win_hit;
            busy       <= (state_nx != IDLE);
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_muon_tdc.sv
`timescale 1ns/1ps
module tb_muon_tdc;
    import muon_pkg::*;

    localparam int TD_A = 1, W_A = 2000, H_A = 100;
    localparam int TD_B = 4, W_B = 300,  H_B = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_in = 1'b0;
    logic stop_in = 1'b0;
    logic clear_counts = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] dig_a, dec_a, dig_b, dec_b;
    logic        mv_a, to_a, busy_a, mv_b, to_b, busy_b;
    tdc_state_t  st_a, st_b;

    muon_tdc #(.TICK_DIV(TD_A), .WINDOW(W_A), .HOLDOFF_CYCLES(H_A)) dut_a (
        .clk(clk), .rst(rst), .start_in(start_in), .stop_in(stop_in),
        .clear_counts(clear_counts), .digits_D(dig_a), .decay_count(dec_a),
        .meas_valid(mv_a), .timeout(to_a), .busy(busy_a), .state_dbg(st_a)
    );

    muon_tdc #(.TICK_DIV(TD_B), .WINDOW(W_B), .HOLDOFF_CYCLES(H_B)) dut_b (
        .clk(clk), .rst(rst), .start_in(start_in), .stop_in(stop_in),
        .clear_counts(clear_counts), .digits_D(dig_b), .decay_count(dec_b),
        .meas_valid(mv_b), .timeout(to_b), .busy(busy_b), .state_dbg(st_b)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    // {cycle[31:0], is_timeout, digits[15:0], decay[15:0]}
    logic [64:0] exp_qa[$];
    logic [64:0] exp_qb[$];

    bit start_ev[int];
    bit stop_ev[int];

    int         td[2]  = '{TD_A, TD_B};
    int         win[2] = '{W_A, W_B};
    int         ho[2]  = '{H_A, H_B};
    tdc_state_t m_state[2] = '{IDLE, IDLE};
    int         t_start[2] = '{0, 0};
    int         ho_end[2]  = '{0, 0};
    int         m_digits[2] = '{0, 0};
    int         m_decay[2]  = '{0, 0};

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int q_size(input int d);
        return (d == 0) ? exp_qa.size() : exp_qb.size();
    endfunction

    function automatic logic [64:0] q_front(input int d);
        return (d == 0) ? exp_qa[0] : exp_qb[0];
    endfunction

    task automatic q_pop(input int d);
        if (d == 0) void'(exp_qa.pop_front());
        else        void'(exp_qb.pop_front());
    endtask

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", name, d, cyc, act, exp);
        end
    endtask

    // ---------------- reference model (event-time based) ----------------
    // Edge r is the clock edge at which the DUT acts on an input edge: an
    // input raised just after edge p is acted on at edge p+3.
    task automatic model_step(input int d, input int r);
        bit st, sp, rec, tout;
        int e;
        logic [64:0] item;
        st = start_ev.exists(r);
        sp = stop_ev.exists(r);
        rec = 1'b0;
        tout = 1'b0;
        e = 0;
        if (rst) begin
            m_state[d]  = IDLE;
            m_digits[d] = 0;
            m_decay[d]  = 0;
        end else begin
            case (m_state[d])
                IDLE: if (st) begin
                    m_state[d] = TIMING;
                    t_start[d] = r;
                end
                TIMING: begin
                    e = (r - t_start[d]) / td[d];
                    if (sp) begin
                        rec = 1'b1;
                        m_state[d] = HOLDOFF;
                        ho_end[d] = r + ho[d];
                    end else if (e >= win[d]) begin
                        tout = 1'b1;
                        m_state[d] = IDLE;
                    end
                end
                default: if (r >= ho_end[d]) m_state[d] = IDLE;
            endcase
            if (rec) begin
                m_digits[d] = e;
                if (m_decay[d] < 9999) m_decay[d]++;
            end
            if (clear_counts) begin
                m_digits[d] = 0;
                m_decay[d]  = 0;
            end
            if (rec || tout) begin
                item = {32'(r), tout, to_bcd(m_digits[d]), to_bcd(m_decay[d])};
                if (d == 0) exp_qa.push_back(item);
                else        exp_qb.push_back(item);
            end
        end
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        model_step(0, cyc);
        model_step(1, cyc);
        if (start_ev.exists(cyc)) start_ev.delete(cyc);
        if (stop_ev.exists(cyc)) stop_ev.delete(cyc);
    end

    // ---------------- monitor ----------------
    task automatic check_dut(input int d, input logic mv, input logic to,
                             input logic [15:0] dig, input logic [15:0] dec,
                             input logic bsy, input tdc_state_t st);
        logic [64:0] e;
        chk("digits", d, 32'(dig), 32'(to_bcd(m_digits[d])));
        chk("decay", d, 32'(dec), 32'(to_bcd(m_decay[d])));
        chk("busy", d, 32'(bsy), 32'(m_state[d] != IDLE));
        chk("state", d, 32'(st), 32'(m_state[d]));
        while (q_size(d) > 0) begin
            e = q_front(d);
            if (e[64:33] >= 32'(cyc)) break;
            chk("pulse_missed", d, 32'(cyc), e[64:33]);
            q_pop(d);
        end
        if (mv !== 1'b0 || to !== 1'b0) begin
            chk("pulse_both", d, 32'(mv & to), 32'd0);
            chk("pulse_expected", d, 32'(q_size(d) > 0), 32'd1);
            if (q_size(d) > 0) begin
                e = q_front(d);
                q_pop(d);
                chk("pulse_cycle", d, 32'(cyc), e[64:33]);
                chk("pulse_kind", d, 32'(to), 32'(e[32]));
                chk("pulse_digits", d, 32'(dig), 32'(e[31:16]));
                chk("pulse_decay", d, 32'(dec), 32'(e[15:0]));
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check_dut(0, mv_a, to_a, dig_a, dec_a, busy_a, st_a);
            check_dut(1, mv_b, to_b, dig_b, dec_b, busy_b, st_b);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input bit s, input bit t, input bit c);
        @(posedge clk);
        #1;
        if (s && !start_in) start_ev[cyc + 3] = 1'b1;
        if (t && !stop_in)  stop_ev[cyc + 3]  = 1'b1;
        start_in = s;
        stop_in = t;
        clear_counts = c;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0, 1'b0);
    endtask

    // Stop edge raised d cycles after the start edge; optionally a clear
    // timed to land on the same edge as the stop record.
    task automatic measure(input int d, input bit clr_coinc);
        tick(1'b1, 1'b0, 1'b0);
        idle(d - 1);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        if (clr_coinc) begin
            tick(1'b0, 1'b0, 1'b1);
            tick(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic chk_pair(input string name, input logic [15:0] ga, input logic [15:0] wa,
                            input logic [15:0] gb, input logic [15:0] wb);
        chk(name, 0, 32'(ga), 32'(wa));
        chk(name, 1, 32'(gb), 32'(wb));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int d;
        int gap;
        bit clr;

        rst = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        mon_en = 1'b1;
        idle(4);
        rst = 1'b0;
        idle(5);
        chk_pair("reset_digits", dig_a, 16'h0000, dig_b, 16'h0000);

        // 220-cycle interval
        measure(220, 1'b0);
        idle(5);
        chk_pair("t220_digits", dig_a, 16'h0220, dig_b, 16'h0055);
        chk_pair("t220_decay", dec_a, 16'h0001, dec_b, 16'h0001);
        chk("t220_busy_holdoff", 0, 32'(busy_a), 32'd1);
        idle(120);

        // 1003-cycle interval: 250 LSBs at TICK_DIV=4
        measure(1003, 1'b0);
        idle(5);
        chk_pair("t1003_digits", dig_a, 16'h1003, dig_b, 16'h0250);
        chk_pair("t1003_decay", dec_a, 16'h0002, dec_b, 16'h0002);
        idle(120);

        // no stop: both windows expire
        tick(1'b1, 1'b0, 1'b0);
        idle(2100);
        chk_pair("timeout_digits", dig_a, 16'h1003, dig_b, 16'h0250);
        chk_pair("timeout_decay", dec_a, 16'h0002, dec_b, 16'h0002);
        chk("timeout_state", 0, 32'(st_a), 32'(IDLE));

        // stop exactly at the window edge for dut_a; dut_b times out first
        measure(2000, 1'b0);
        idle(5);
        chk_pair("window_digits", dig_a, 16'h2000, dig_b, 16'h0250);
        chk_pair("window_decay", dec_a, 16'h0003, dec_b, 16'h0002);
        idle(120);

        // stop in IDLE, start+stop together, retrigger attempt mid-TIMING
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        idle(40);
        tick(1'b1, 1'b0, 1'b0);
        idle(40);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        idle(5);
        chk_pair("noretrig_digits", dig_a, 16'h0082, dig_b, 16'h0020);
        chk_pair("noretrig_decay", dec_a, 16'h0004, dec_b, 16'h0003);
        idle(120);

        // stop during HOLDOFF cycle 50 is ignored, then a 10-cycle interval
        measure(30, 1'b0);
        idle(48);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        idle(70);
        measure(10, 1'b0);
        idle(5);
        chk_pair("holdoff_digits", dig_a, 16'h0010, dig_b, 16'h0002);
        chk_pair("holdoff_decay", dec_a, 16'h0006, dec_b, 16'h0005);
        idle(120);

        // randomized intervals, gaps, spurious stops and clears
        for (int i = 0; i < 20; i++) begin
            d = $urandom_range(2200, 1);
            gap = $urandom_range(150, 0);
            clr = ($urandom_range(7, 0) == 0);
            measure(d, clr);
            if ($urandom_range(3, 0) == 0) begin
                tick(1'b0, 1'b1, 1'b0);
                tick(1'b0, 1'b0, 1'b0);
            end
            idle(gap);
        end
        idle(150);

        // reset in the middle of a measurement
        tick(1'b1, 1'b0, 1'b0);
        idle(100);
        chk_pair("pre_rst_busy", 16'(busy_a), 16'h0001, 16'(busy_b), 16'h0001);
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(3);
        chk_pair("rst_digits", dig_a, 16'h0000, dig_b, 16'h0000);
        chk_pair("rst_decay", dec_a, 16'h0000, dec_b, 16'h0000);
        chk_pair("rst_busy", 16'(busy_a), 16'h0000, 16'(busy_b), 16'h0000);
        idle(10);

        // saturate dut_b's decay count with back-to-back short decays
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10003; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            tick(1'b0, 1'b1, 1'b0);
            tick(1'b0, 1'b0, 1'b0);
        end
        idle(120);
        chk("sat_decay", 1, 32'(dec_b), 32'h9999);
        chk("sat_digits", 1, 32'(dig_b), 32'h0000);

        // clear on the same edge as a stop record
        measure(5, 1'b1);
        idle(5);
        chk_pair("clr_coinc_digits", dig_a, 16'h0000, dig_b, 16'h0000);
        chk_pair("clr_coinc_decay", dec_a, 16'h0000, dec_b, 16'h0000);
        idle(120);

        chk("queue_empty", 0, 32'(exp_qa.size()), 32'd0);
        chk("queue_empty", 1, 32'(exp_qb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
